// File: rtl/mmio_fabric.sv
// MMIO fabric: decodes CPU accesses onto up to 16 peripheral slots by 64 KiB page,
// forwards busy/read data from the selected slot, and reports decode and
// timeout errors through a sticky flag that remembers the first faulting address.
module mmio_fabric #(
   parameter int unsigned           NSLOT      = 4,
   parameter logic [NSLOT*16-1:0]   SLOT_PAGES = {16'h0001, 16'h0040, 16'h0001, 16'h0000},
   parameter int unsigned           TIMEOUT    = 255,
   parameter logic [31:0]           ERR_DATA   = 32'hFFFF_FFFF
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [31:0]           mem_addr,
   input  logic                  mem_rstrb,
   input  logic [3:0]            mem_wmask,
   output logic [31:0]           mem_rdata,
   output logic                  mem_rbusy,
   output logic                  mem_wbusy,
   output logic [NSLOT-1:0]      per_rd,
   output logic [NSLOT-1:0]      per_wr,
   input  logic [NSLOT*32-1:0]   per_rdata,
   input  logic [NSLOT-1:0]      per_rbusy,
   input  logic [NSLOT-1:0]      per_wbusy,
   output logic                  err_irq,
   output logic [31:0]           err_addr,
   input  logic                  err_clr
);

   localparam int unsigned SEL_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RWAIT = 2'd1,
      WWAIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [CNT_W-1:0]    wcnt_q, wcnt_d;
   logic                derr_q, derr_d;
   logic                err_irq_q;
   logic [31:0]         err_addr_q;

   logic                hit;
   logic [SEL_W-1:0]    hit_idx;
   logic                raise;
   logic                timeout;
   logic [31:0]         sel_rdata;
   logic [NSLOT-1:0]    rd_pulse, wr_pulse;

   // Page decode: lowest matching slot wins when pages overlap.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int s = int'(NSLOT) - 1; s >= 0; s--) begin
         if (mem_addr[31:16] == SLOT_PAGES[16*s +: 16]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(s);
         end
      end
   end

   assign sel_rdata = per_rdata[32*int'(sel_q) +: 32];
   assign timeout   = (wcnt_q == CNT_W'(TIMEOUT - 1));

   // Next-state, strobe forwarding and CPU-side busy/data muxing.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      wcnt_d    = wcnt_q;
      derr_d    = derr_q;
      raise     = 1'b0;
      rd_pulse  = '0;
      wr_pulse  = '0;
      mem_rbusy = 1'b0;
      mem_wbusy = 1'b0;
      mem_rdata = derr_q ? ERR_DATA : sel_rdata;
      unique case (state_q)
         IDLE: begin
            if ((|mem_wmask) || mem_rstrb) begin
               if (hit) begin
                  sel_d  = hit_idx;
                  wcnt_d = '0;
                  derr_d = 1'b0;
                  if (|mem_wmask) begin
                     wr_pulse[hit_idx] = 1'b1;
                     state_d           = WWAIT;
                  end else begin
                     rd_pulse[hit_idx] = 1'b1;
                     state_d           = RWAIT;
                  end
               end else begin
                  derr_d = 1'b1;
                  raise  = 1'b1;
               end
            end
         end
         RWAIT: begin
            mem_rdata = sel_rdata;
            if (per_rbusy[sel_q]) begin
               if (timeout) begin
                  mem_rdata = ERR_DATA;
                  raise     = 1'b1;
                  state_d   = IDLE;
               end else begin
                  mem_rbusy = 1'b1;
                  wcnt_d    = CNT_W'(wcnt_q + 1'b1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         WWAIT: begin
            if (per_wbusy[sel_q]) begin
               if (timeout) begin
                  raise   = 1'b1;
                  state_d = IDLE;
               end else begin
                  mem_wbusy = 1'b1;
                  wcnt_d    = CNT_W'(wcnt_q + 1'b1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Peripheral strobes are suppressed while reset is held.
   assign per_rd = resetn ? rd_pulse : '0;
   assign per_wr = resetn ? wr_pulse : '0;

   // FSM and access-tracking registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         sel_q   <= '0;
         wcnt_q  <= '0;
         derr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         wcnt_q  <= wcnt_d;
         derr_q  <= derr_d;
      end
   end

   // Sticky error flag; a new error beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         err_irq_q  <= 1'b0;
         err_addr_q <= '0;
      end else if (raise) begin
         err_irq_q <= 1'b1;
         if (!err_irq_q || err_clr) begin
            err_addr_q <= mem_addr;
         end
      end else if (err_clr) begin
         err_irq_q  <= 1'b0;
         err_addr_q <= '0;
      end
   end

   assign err_irq  = err_irq_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed bench for mmio_fabric: slot1 on page 0x0040, slots 2/3 overlapping
// on page 0x0001, slot0 on page 0x0000, TIMEOUT=4.
module tb_mmio_fabric;

   localparam int unsigned NSLOT = 4;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic [31:0]          mem_addr;
   logic                 mem_rstrb;
   logic [3:0]           mem_wmask;
   logic [31:0]          mem_rdata;
   logic                 mem_rbusy;
   logic                 mem_wbusy;
   logic [NSLOT-1:0]     per_rd;
   logic [NSLOT-1:0]     per_wr;
   logic [NSLOT*32-1:0]  per_rdata;
   logic [NSLOT-1:0]     per_rbusy;
   logic [NSLOT-1:0]     per_wbusy;
   logic                 err_irq;
   logic [31:0]          err_addr;
   logic                 err_clr;

   int checks = 0;
   int errors = 0;

   mmio_fabric #(
      .NSLOT      (NSLOT),
      .SLOT_PAGES ({16'h0001, 16'h0001, 16'h0040, 16'h0000}),
      .TIMEOUT    (4),
      .ERR_DATA   (32'hFFFF_FFFF)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_addr  (mem_addr),
      .mem_rstrb (mem_rstrb),
      .mem_wmask (mem_wmask),
      .mem_rdata (mem_rdata),
      .mem_rbusy (mem_rbusy),
      .mem_wbusy (mem_wbusy),
      .per_rd    (per_rd),
      .per_wr    (per_wr),
      .per_rdata (per_rdata),
      .per_rbusy (per_rbusy),
      .per_wbusy (per_wbusy),
      .err_irq   (err_irq),
      .err_addr  (err_addr),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, then settle after new drives.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn    = 1'b0;
      mem_addr  = 32'h0000_0000;
      mem_rstrb = 1'b1;
      mem_wmask = 4'h0;
      per_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hA0A0_A0A0};
      per_rbusy = '0;
      per_wbusy = '0;
      err_clr   = 1'b0;

      // Reset: strobes must not leak to peripherals.
      #1;
      chk("rst_per_rd", 32'(per_rd), 32'h0);
      step();
      step();
      chk("rst_per_rd2", 32'(per_rd), 32'h0);
      mem_rstrb = 1'b0;
      resetn    = 1'b1;
      #1;
      chk("rst_rbusy", 32'(mem_rbusy), 32'h0);
      chk("rst_wbusy", 32'(mem_wbusy), 32'h0);
      chk("rst_rdata", mem_rdata, 32'hA0A0_A0A0);
      chk("rst_irq", 32'(err_irq), 32'h0);
      chk("rst_eaddr", err_addr, 32'h0);

      // Read slot1 with 3 busy cycles.
      step();
      mem_addr  = 32'h0040_0004;
      mem_rstrb = 1'b1;
      per_rbusy = 4'b0010;
      #1;
      chk("rd1_per_rd", 32'(per_rd), 32'h2);
      chk("rd1_rbusy0", 32'(mem_rbusy), 32'h0);
      step();
      mem_rstrb = 1'b1;
      #1;
      chk("rd1_ignore", 32'(per_rd), 32'h0);
      chk("rd1_busy_c1", 32'(mem_rbusy), 32'h1);
      mem_rstrb = 1'b0;
      step();
      chk("rd1_busy_c2", 32'(mem_rbusy), 32'h1);
      step();
      chk("rd1_busy_c3", 32'(mem_rbusy), 32'h1);
      step();
      per_rbusy = 4'b0000;
      #1;
      chk("rd1_done", 32'(mem_rbusy), 32'h0);
      chk("rd1_rdata", mem_rdata, 32'h1234_5678);
      step();
      chk("rd1_idle_rdata", mem_rdata, 32'h1234_5678);
      chk("rd1_irq", 32'(err_irq), 32'h0);

      // Write to overlapping page with simultaneous read strobe: slot2 only, write wins.
      mem_addr  = 32'h0001_0010;
      mem_wmask = 4'b1111;
      mem_rstrb = 1'b1;
      per_wbusy = 4'b1100;
      #1;
      chk("wr_per_wr", 32'(per_wr), 32'h4);
      chk("wr_per_rd", 32'(per_rd), 32'h0);
      step();
      mem_wmask = 4'h0;
      mem_rstrb = 1'b0;
      per_wbusy = 4'b0100;
      #1;
      chk("wr_wbusy1", 32'(mem_wbusy), 32'h1);
      chk("wr_rbusy", 32'(mem_rbusy), 32'h0);
      chk("wr_ignore", 32'(per_wr), 32'h0);
      step();
      per_wbusy = 4'b1000;
      #1;
      chk("wr_slot3_ignored", 32'(mem_wbusy), 32'h0);
      step();
      per_wbusy = 4'b1111;
      #1;
      chk("wr_idle_wbusy", 32'(mem_wbusy), 32'h0);
      per_wbusy = 4'b0000;

      // Decode error on read.
      step();
      mem_addr  = 32'h0099_0000;
      mem_rstrb = 1'b1;
      #1;
      chk("de_per_rd", 32'(per_rd), 32'h0);
      chk("de_rbusy", 32'(mem_rbusy), 32'h0);
      step();
      mem_rstrb = 1'b0;
      #1;
      chk("de_rdata", mem_rdata, 32'hFFFF_FFFF);
      chk("de_rbusy2", 32'(mem_rbusy), 32'h0);
      chk("de_irq", 32'(err_irq), 32'h1);
      chk("de_eaddr", err_addr, 32'h0099_0000);

      // Timeout on slot0 stuck busy; first error address kept.
      mem_addr  = 32'h0000_0008;
      mem_rstrb = 1'b1;
      per_rbusy = 4'b0001;
      #1;
      chk("to_per_rd", 32'(per_rd), 32'h1);
      step();
      mem_rstrb = 1'b0;
      #1;
      chk("to_busy_c1", 32'(mem_rbusy), 32'h1);
      step();
      chk("to_busy_c2", 32'(mem_rbusy), 32'h1);
      step();
      chk("to_busy_c3", 32'(mem_rbusy), 32'h1);
      step();
      chk("to_forced", 32'(mem_rbusy), 32'h0);
      chk("to_rdata", mem_rdata, 32'hFFFF_FFFF);
      step();
      per_rbusy = 4'b0000;
      #1;
      chk("to_idle_rdata", mem_rdata, 32'hA0A0_A0A0);
      chk("to_irq", 32'(err_irq), 32'h1);
      chk("to_eaddr_kept", err_addr, 32'h0099_0000);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      #1;
      chk("clr_irq", 32'(err_irq), 32'h0);
      chk("clr_eaddr", err_addr, 32'h0);

      // Reset during WWAIT abandons the write without an error.
      mem_addr  = 32'h0001_0000;
      mem_wmask = 4'b0001;
      per_wbusy = 4'b0100;
      #1;
      chk("rw_per_wr", 32'(per_wr), 32'h4);
      step();
      mem_wmask = 4'h0;
      #1;
      chk("rw_wbusy", 32'(mem_wbusy), 32'h1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      #1;
      chk("rw_wbusy_rst", 32'(mem_wbusy), 32'h0);
      chk("rw_irq", 32'(err_irq), 32'h0);
      chk("rw_rdata", mem_rdata, 32'hA0A0_A0A0);
      per_wbusy = 4'b0000;

      // Zero-wait read of slot0 takes two cycles, then a new access is accepted.
      mem_addr  = 32'h0000_0000;
      mem_rstrb = 1'b1;
      #1;
      chk("zw_per_rd", 32'(per_rd), 32'h1);
      step();
      mem_rstrb = 1'b0;
      #1;
      chk("zw_rbusy", 32'(mem_rbusy), 32'h0);
      chk("zw_rdata", mem_rdata, 32'hA0A0_A0A0);
      step();
      mem_addr  = 32'h0040_0000;
      mem_rstrb = 1'b1;
      #1;
      chk("zw_next_acc", 32'(per_rd), 32'h2);
      step();
      mem_rstrb = 1'b0;
      step();

      // Decode error on write, then clear and new error in the same cycle.
      mem_addr  = 32'h00AA_0000;
      mem_wmask = 4'b0001;
      #1;
      chk("dw_per_wr", 32'(per_wr), 32'h0);
      chk("dw_wbusy", 32'(mem_wbusy), 32'h0);
      step();
      mem_wmask = 4'h0;
      #1;
      chk("dw_eaddr", err_addr, 32'h00AA_0000);
      mem_addr  = 32'h00BB_0000;
      mem_rstrb = 1'b1;
      err_clr   = 1'b1;
      step();
      mem_rstrb = 1'b0;
      err_clr   = 1'b0;
      #1;
      chk("cn_irq", 32'(err_irq), 32'h1);
      chk("cn_eaddr", err_addr, 32'h00BB_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_fabric.md
MMIO_FABRIC -- requirements
Module: mmio_fabric

Interface
REQ-001 Parameter NSLOT, default 4: number of peripheral slots, range 1..16.
REQ-002 Parameter SLOT_PAGES, default {16'h0001,16'h0040,16'h0001,16'h0000} (slot0 in LSBs): NSLOT x 16-bit page values, compared against mem_addr[31:16].
REQ-003 Parameter TIMEOUT, default 255: maximum wait cycles per access, range 2..65535.
REQ-004 Parameter ERR_DATA, default 32'hFFFF_FFFF: read data returned on error.
REQ-005 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-006 Port resetn  in  1: synchronous, active-low reset.
REQ-007 Port mem_addr  in  32: CPU byte address.
REQ-008 Port mem_rstrb  in  1: CPU read strobe, one-cycle pulse.
REQ-009 Port mem_wmask  in  4: CPU byte write mask; any bit set indicates a write.
REQ-010 Port mem_rdata  out  32: read data to the CPU.
REQ-011 Ports mem_rbusy and mem_wbusy  out  1 each: CPU stall signals.
REQ-012 Ports per_rd and per_wr  out  NSLOT each: per-slot read and write pulses.
REQ-013 Port per_rdata  in  NSLOT*32: slot s occupies bits [32s+31:32s].
REQ-014 Ports per_rbusy and per_wbusy  in  NSLOT each: per-slot busy inputs.
REQ-015 Port err_irq  out  1: sticky bus-error flag.
REQ-016 Port err_addr  out  32: mem_addr of the first unacknowledged error.
REQ-017 Port err_clr  in  1: clears err_irq and err_addr.

Function
REQ-018 Decode is combinational: the slot is the lowest index s with mem_addr[31:16]==SLOT_PAGES[s]; if no slot matches, the access is a decode error.
REQ-019 FSM states are IDLE, RWAIT and WWAIT.
REQ-020 In IDLE, when |mem_wmask is set and a slot matches, per_wr[s]=1 for that cycle, sel_q<=s, and the next state is WWAIT.
REQ-021 In IDLE, when mem_rstrb=1, mem_wmask=0 and a slot matches, per_rd[s]=1 for that cycle, sel_q<=s, and the next state is RWAIT.
REQ-022 When mem_rstrb and a nonzero mem_wmask occur together, the write takes priority and no per_rd pulse is issued.
REQ-023 per_rd and per_wr are zero except as defined in REQ-020 and REQ-021; every pulse is exactly one cycle, with at most one bit set.
REQ-024 Strobes received in RWAIT or WWAIT are ignored and produce no per_rd or per_wr pulse.
REQ-025 In RWAIT, mem_rbusy=per_rbusy[sel_q] and mem_rdata=per_rdata[sel_q]; when per_rbusy[sel_q]=0, the next state is IDLE.
REQ-026 In WWAIT, mem_wbusy=per_wbusy[sel_q]; when per_wbusy[sel_q]=0, the next state is IDLE.
REQ-027 Outside RWAIT, mem_rbusy=0; outside WWAIT, mem_wbusy=0.
REQ-028 A zero-wait slot (busy never asserted) completes in 2 cycles: the strobe cycle plus one cycle in the wait state.
REQ-029 wcnt clears on entry to RWAIT/WWAIT and increments each cycle the FSM stays in RWAIT/WWAIT.
REQ-030 In the cycle where wcnt==TIMEOUT-1 and the selected busy is still 1: the busy output is forced to 0, mem_rdata=ERR_DATA in RWAIT, a timeout error is raised, and the next state is IDLE.
REQ-031 A strobe to an unmatched address causes no per_* pulse and no stall; mem_rdata=ERR_DATA from the next cycle until the next accepted access; a decode error is raised.
REQ-032 In IDLE, mem_rdata=per_rdata[sel_q] unless REQ-031 applies.
REQ-033 Raising an error sets err_irq=1; err_addr is loaded only when err_irq was 0, so the first error is kept.
REQ-034 err_clr=1 clears err_irq and err_addr to 0; if a new error is raised in the same cycle, the new error wins.

Reset
REQ-035 While resetn=0 at a rising clk edge: state<=IDLE, sel_q<=0, wcnt<=0, err_irq<=0, err_addr<=0, and the decode-error data flag is cleared.
REQ-036 per_rd=0 and per_wr=0 whenever resetn=0.
REQ-037 After reset: mem_rbusy=0, mem_wbusy=0, mem_rdata=per_rdata[0].
REQ-038 Reset asserted during RWAIT or WWAIT abandons the access; no error is raised.

Verification
REQ-039 Read 0x0040_0004 with slot1 busy for 3 cycles and rdata=0x12345678 -> per_rd[1] high for 1 cycle, mem_rbusy high 3 cycles, mem_rdata=0x12345678 when mem_rbusy falls.
REQ-040 Write mask 4'b1111 to 0x0001_0010 while slot2 and slot3 overlap on page 0x0001 -> only per_wr[2] pulses; mem_wbusy follows per_wbusy[2].
REQ-041 Read 0x0099_0000 -> no per_rd pulse, mem_rbusy=0, mem_rdata=0xFFFF_FFFF, err_irq=1, err_addr=0x0099_0000.
REQ-042 TIMEOUT=4, slot0 rbusy stuck at 1 -> mem_rbusy high 3 cycles then 0, mem_rdata=ERR_DATA, err_irq=1; a second error before err_clr leaves err_addr unchanged.
REQ-043 resetn low for 1 cycle during WWAIT -> FSM in IDLE, mem_wbusy=0, err_irq=0; a following read to slot0 completes normally.
REQ-044 err_clr and a new decode error in the same cycle -> err_irq=1, err_addr equals the new address.
